mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the MIPS execute stage. It sits beside the single-cycle ALU and takes the same operand pair. Unlike the ALU, it completes its operations over several clocks and holds results in architectural HI/LO registers. The pipeline controller stalls mfhi/mflo and new MD instructions while `busy` is high.

## Interface
- `MUL_CYCLES`, default 5: cycles `busy` stays high for mult/multu.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: issue pulse; sampled only when `busy`=0.
- `MDop` in 3: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- `In1` in 32: rs operand (dividend / multiplicand / mthi-mtlo source).
- `In2` in 32: rt operand (divisor / multiplier).
- `busy` out 1: operation in flight.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, `start`=1, mult/multu: capture operands and signedness, go to MUL, load counter with `MUL_CYCLES`-1.
- IDLE, `start`=1, div/divu: load magnitudes (signed case: abs of each, record sign of quotient and of dividend), go to DIV, counter=31.
- IDLE, `start`=1, mthi/mtlo: write `In1` to HI/LO at that edge, stay IDLE, `busy` stays 0.
- `start` while `busy`=1: ignored, with no effect on state or operands.
- `start` with none/reserved op: no effect.
- MUL: decrement counter each cycle. At counter 0, write the 64-bit product {HI,LO} and go to IDLE.
  - Signed product: two's-complement of In1×In2.
  - Unsigned product: zero-extended.
- DIV: one restoring step per cycle for 32 cycles, MSB first: shift {rem,quot} left, trial-subtract divisor, set quotient bit if non-negative. Then go to FIX.
- FIX: apply signs, write LO=quotient and HI=remainder, go to IDLE.
  - Quotient is negated when operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero (div/divu): full latency still applies. Result LO=0xFFFFFFFF, HI=In1 as captured.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (falls out of the magnitude arithmetic; no special case).
- HI/LO keep their old values until the final commit edge. Operands are captured at issue, so later changes to `In1`/`In2` have no effect.

## Timing
- Reset: state IDLE, `busy`=0, HI=0, LO=0, counter 0.
- Reset mid-operation aborts it. HI/LO are cleared, not committed.
- Issue edge T: `busy`=1 from T+1.
- mult/multu: `busy` high for exactly `MUL_CYCLES` cycles. New HI/LO are visible in the same cycle `busy` falls.
- div/divu: `busy` high for exactly 33 cycles (32 DIV + 1 FIX). HI/LO are visible when `busy` falls.
- Back-to-back: `start` in the first cycle with `busy`=0 is accepted. There is no idle gap requirement.
- mthi/mtlo: HI/LO are visible the cycle after the edge. No `busy` pulse.

## Structure
- Package `md_pkg` holds:
  - MDop encodings;
  - state encoding (IDLE/MUL/DIV/FIX);
  - `DIV_STEPS`=32;
  - the default `MUL_CYCLES`.
- Sub-module `div_core`: the iterative restoring divider. Interface: load, 32-bit magnitudes in, step enable, 32-bit quotient/remainder out.
- The top level owns the FSM, counter, sign handling, and the HI/LO registers.

## Test plan
- Reset, then `start` with mult, In1=0xFFFFFFFE (-2), In2=3 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div In1=0xFFFFFFF9 (-7), In2=2 → `busy` 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 → LO=14, HI=2.
- divu In2=0 with In1=0x1234 → after 33 cycles LO=0xFFFFFFFF, HI=0x1234. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0xAAAA0000 then mtlo 0x5555 on consecutive cycles → `busy` never asserted, HI=0xAAAA0000, LO=0x5555. During a div, `start` mult → ignored, only the div result is committed.
- Start a div, assert `reset` at busy cycle 10 → next cycle `busy`=0, HI=LO=0. Immediately issue mult 6×7 → LO=42, HI=0 after 5 cycles.
- Change `In1`/`In2` every cycle during a mult → the result reflects the operands captured at the issue edge.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and state
// encodings, iteration counts and a small magnitude helper.
package md_pkg;

   // Opcode carried on MDop from the decode stage.
   typedef enum logic [2:0] {
      MD_NONE  = 3'b000,
      MD_MULT  = 3'b001,
      MD_MULTU = 3'b010,
      MD_DIV   = 3'b011,
      MD_DIVU  = 3'b100,
      MD_MTHI  = 3'b101,
      MD_MTLO  = 3'b110,
      MD_RSVD  = 3'b111
   } mdop_e;

   // Control FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   localparam int DIV_STEPS       = 32;
   localparam int MUL_CYCLES_DEF  = 5;
   // Wide enough for DIV_STEPS-1 and any sensible MUL_CYCLES-1.
   localparam int CNT_W           = 8;

   // Magnitude of a two's-complement word; 0x80000000 maps to itself,
   // which is exactly the unsigned magnitude 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider on 32-bit magnitudes: one quotient bit per
// enabled cycle, MSB first. A zero divisor yields an all-ones quotient and
// leaves the dividend in the remainder.
module div_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic        step_i,
   output logic [31:0] quot_o,
   output logic [31:0] rem_o
);

   logic [31:0] quot_q;
   logic [31:0] rem_q;
   logic [31:0] dvsr_q;
   logic [32:0] shifted_d;
   logic [32:0] diff_d;

   // Shift the next dividend bit into the partial remainder and trial-subtract.
   always_comb begin
      shifted_d = {rem_q, quot_q[31]};
      diff_d    = shifted_d - {1'b0, dvsr_q};
   end

   // Load operands on issue, then keep the difference only when it is non-negative.
   always_ff @(posedge clk) begin
      if (reset) begin
         quot_q <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
      end else if (load_i) begin
         quot_q <= dividend_i;
         rem_q  <= '0;
         dvsr_q <= divisor_i;
      end else if (step_i) begin
         if (!diff_d[32]) begin
            rem_q  <= diff_d[31:0];
            quot_q <= {quot_q[30:0], 1'b1};
         end else begin
            rem_q  <= shifted_d[31:0];
            quot_q <= {quot_q[30:0], 1'b0};
         end
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Owns the control FSM, the latency counter, sign handling and HI/LO;
// the bit-serial division itself lives in div_core.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDop,
   input  logic [31:0] In1,
   input  logic [31:0] In2,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   md_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]     a_q;        // raw In1 at issue
   logic [31:0]     b_q;        // raw In2 at issue
   logic            sgn_q;      // signed multiply
   logic            q_neg_q;    // quotient must be negated
   logic            r_neg_q;    // remainder takes a negative dividend's sign
   logic            dz_q;       // divisor was zero
   logic [31:0]     hi_q;
   logic [31:0]     lo_q;

   mdop_e           op_d;
   logic            issue_div_d;
   logic            div_signed_d;
   logic [63:0]     ext_a_d;
   logic [63:0]     ext_b_d;
   logic [63:0]     prod_d;
   logic [31:0]     quot_w;
   logic [31:0]     rem_w;
   logic [31:0]     q_fix_d;
   logic [31:0]     r_fix_d;

   // Decode the issue request and form the product / sign-corrected quotient.
   always_comb begin
      op_d         = mdop_e'(MDop);
      issue_div_d  = (state_q == ST_IDLE) && start &&
                     ((op_d == MD_DIV) || (op_d == MD_DIVU));
      div_signed_d = (op_d == MD_DIV);
      // Extending to 64 bits and keeping the low 64 bits of the product gives
      // the correct two's-complement result for both signednesses.
      ext_a_d      = {{32{sgn_q & a_q[31]}}, a_q};
      ext_b_d      = {{32{sgn_q & b_q[31]}}, b_q};
      prod_d       = ext_a_d * ext_b_d;
      q_fix_d      = q_neg_q ? (~quot_w + 32'd1) : quot_w;
      r_fix_d      = r_neg_q ? (~rem_w + 32'd1) : rem_w;
   end

   div_core u_div (
      .clk        (clk),
      .reset      (reset),
      .load_i     (issue_div_d),
      .dividend_i (div_signed_d ? abs32(In1) : In1),
      .divisor_i  (div_signed_d ? abs32(In2) : In2),
      .step_i     (state_q == ST_DIV),
      .quot_o     (quot_w),
      .rem_o      (rem_w)
   );

   // Control FSM: issue, count down the latency, commit HI/LO on the last edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  case (op_d)
                     MD_MULT, MD_MULTU: begin
                        a_q     <= In1;
                        b_q     <= In2;
                        sgn_q   <= (op_d == MD_MULT);
                        cnt_q   <= CNT_W'(MUL_CYCLES - 1);
                        state_q <= ST_MUL;
                     end
                     MD_DIV, MD_DIVU: begin
                        a_q     <= In1;
                        b_q     <= In2;
                        q_neg_q <= div_signed_d & (In1[31] ^ In2[31]);
                        r_neg_q <= div_signed_d & In1[31];
                        dz_q    <= (In2 == 32'd0);
                        cnt_q   <= CNT_W'(DIV_STEPS - 1);
                        state_q <= ST_DIV;
                     end
                     MD_MTHI: hi_q <= In1;
                     MD_MTLO: lo_q <= In1;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (cnt_q == '0) begin
                  hi_q    <= prod_d[63:32];
                  lo_q    <= prod_d[31:0];
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DIV: begin
               if (cnt_q == '0) begin
                  state_q <= ST_FIX;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_FIX: begin
               // A zero divisor reports an all-ones quotient regardless of
               // signs, and hands the original dividend back in HI.
               if (dz_q) begin
                  lo_q <= 32'hFFFF_FFFF;
                  hi_q <= a_q;
               end else begin
                  lo_q <= q_fix_d;
                  hi_q <= r_fix_d;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a table of operations applied
// back-to-back, expected HI/LO/latency queued at issue and compared when
// busy falls, plus hand sequences for mthi/mtlo and mid-operation reset.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  MDop;
   logic [31:0] In1;
   logic [31:0] In2;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
      int          inject;   // busy cycle at which a mult start is attempted (0 = none)
      bit          scramble; // change In1/In2 every cycle while busy
      string       name;
   } vec_t;

   typedef struct {
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[16];

   mult_div_unit #(.MUL_CYCLES(5)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .MDop  (MDop),
      .In1   (In1),
      .In2   (In2),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %08h required %08h", name, got, want);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   // Called at a negedge with busy=0: issue, count busy cycles, then compare.
   task automatic run_op(input vec_t v);
      exp_t        e;
      int          n;
      logic [31:0] hi0;
      logic [31:0] lo0;
      hi0 = HI;
      lo0 = LO;
      e.lat = v.lat; e.hi = v.hi; e.lo = v.lo; e.name = v.name;
      sb_q.push_back(e);
      start = 1'b1; MDop = v.op; In1 = v.a; In2 = v.b;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (n == 1) begin
            check32({v.name, " hi_hold"}, HI, hi0);
            check32({v.name, " lo_hold"}, LO, lo0);
         end
         if (v.scramble) begin
            In1 = $urandom; In2 = $urandom;
         end
         if (v.inject != 0 && n == v.inject) begin
            start = 1'b1; MDop = 3'b001; In1 = 32'd6; In2 = 32'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (sb_q.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s: scoreboard empty got 0 required 1", v.name);
      end else begin
         e = sb_q.pop_front();
         check_int({e.name, " busy_cycles"}, n, e.lat);
         check32({e.name, " HI"}, HI, e.hi);
         check32({e.name, " LO"}, LO, e.lo);
         $display("op %s: busy=%0d HI=%08h LO=%08h", e.name, n, HI, LO);
      end
   endtask

   initial begin
      vec_t v;
      int   n;

      vecs[0]  = '{3'b001, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, "mult -2*3"};
      vecs[1]  = '{3'b010, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA, 0, 0, "multu fffffffe*3"};
      vecs[2]  = '{3'b111, 32'h11111111, 32'h22222222, 0,  32'h00000002, 32'hFFFFFFFA, 0, 0, "reserved op"};
      vecs[3]  = '{3'b000, 32'h33333333, 32'h44444444, 0,  32'h00000002, 32'hFFFFFFFA, 0, 0, "none op"};
      vecs[4]  = '{3'b011, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, "div -7/2"};
      vecs[5]  = '{3'b100, 32'd100,      32'd7,        33, 32'd2,        32'd14,       5, 0, "divu 100/7 +mult"};
      vecs[6]  = '{3'b100, 32'h00001234, 32'd0,        33, 32'h00001234, 32'hFFFFFFFF, 0, 0, "divu by 0"};
      vecs[7]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000, 0, 0, "div min/-1"};
      vecs[8]  = '{3'b011, 32'd7,        32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD, 0, 0, "div 7/-2"};
      vecs[9]  = '{3'b011, 32'hFFFFFFF0, 32'd0,        33, 32'hFFFFFFF0, 32'hFFFFFFFF, 0, 0, "div -16/0"};
      vecs[10] = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, 0, 0, "multu max*max"};
      vecs[11] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001, 0, 0, "mult -1*-1"};
      vecs[12] = '{3'b001, 32'd6,        32'd7,        5,  32'h00000000, 32'd42,       0, 1, "mult 6*7 scrambled"};
      vecs[13] = '{3'b101, 32'h12345678, 32'd0,        0,  32'h12345678, 32'd42,       0, 0, "mthi"};
      vecs[14] = '{3'b110, 32'd9,        32'd0,        0,  32'h12345678, 32'd9,        0, 0, "mtlo"};
      vecs[15] = '{3'b001, 32'h7FFFFFFF, 32'h80000000, 5,  32'hC0000000, 32'h80000000, 0, 0, "mult max*min"};

      reset = 1'b1; start = 1'b0; MDop = 3'b000; In1 = '0; In2 = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_int("reset busy", int'(busy), 0);
      check32("reset HI", HI, 32'h0);
      check32("reset LO", LO, 32'h0);

      // Table vectors, each issued in the first idle cycle after the previous.
      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i]);
      end

      // mthi then mtlo on consecutive cycles: no busy pulse.
      start = 1'b1; MDop = 3'b101; In1 = 32'hAAAA0000;
      @(negedge clk);
      check_int("mthi busy", int'(busy), 0);
      MDop = 3'b110; In1 = 32'h00005555;
      @(negedge clk);
      start = 1'b0;
      check_int("mtlo busy", int'(busy), 0);
      check32("mthi/mtlo HI", HI, 32'hAAAA0000);
      check32("mthi/mtlo LO", LO, 32'h00005555);
      $display("op mthi/mtlo: HI=%08h LO=%08h", HI, LO);

      // Reset at busy cycle 10 of a div aborts it and clears HI/LO.
      start = 1'b1; MDop = 3'b011; In1 = 32'hFFFFFFF9; In2 = 32'd2;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (busy && n < 10) begin
         n++;
         if (n < 10) @(negedge clk);
      end
      check_int("div before reset busy_cycles", n, 10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_int("abort busy", int'(busy), 0);
      check32("abort HI", HI, 32'h0);
      check32("abort LO", LO, 32'h0);
      $display("op div aborted by reset: busy=%0d HI=%08h LO=%08h", busy, HI, LO);

      v = '{3'b001, 32'd6, 32'd7, 5, 32'h0, 32'd42, 0, 0, "mult 6*7 after reset"};
      run_op(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
